fifo_ctrl_16x8: RTL and testbench

Synchronous FIFO controller that sequences the 16x8 dual-port RAM (`ram_dual_16x8`) as a first-word-fall-through queue between one producer and one consumer. Both sides use valid/ready handshakes. A 2-entry output buffer hides the RAM's 1-cycle registered read latency, so the queue sustains one push and one pop per cycle. The block sits between byte-stream sources (UART RX, sensor capture) and their consumers in the FPGA lab designs.

---
 rtl/fifo_ctrl_16x8_pkg.sv | 17 +
 rtl/ram_dual_16x8.sv | 27 ++
 rtl/fifo_ctrl_16x8.sv | 100 ++++++++++
 tb/tb_fifo_ctrl_16x8.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_16x8_pkg.sv
// Shared constants for the 16x8 FIFO controller and its storage RAM.
// The stream-source blocks use the same width/depth constants.
package fifo_ctrl_16x8_pkg;

   localparam int unsigned FIFO_D_WIDTH = 8;
   localparam int unsigned FIFO_A_WIDTH = 4;
   localparam int unsigned FIFO_DEPTH   = 1 << FIFO_A_WIDTH;

   // A RAM fetch may start only if, after this cycle's pop, the buffered
   // words plus the one already in flight leave room for one more.
   function automatic logic fetch_ok(input logic [1:0] buf_cnt,
                                     input logic       pend,
                                     input logic       pop);
      return ({1'b0, buf_cnt} + {2'b00, pend}) < (3'd2 + {2'b00, pop});
   endfunction

endpackage

// File: rtl/ram_dual_16x8.sv
// Simple dual-port RAM: one write port, one read port, registered read
// data (read-before-write on an address collision).
module ram_dual_16x8
   import fifo_ctrl_16x8_pkg::*;
#(
   parameter int unsigned D_WIDTH = FIFO_D_WIDTH,
   parameter int unsigned A_WIDTH = FIFO_A_WIDTH
) (
   input  logic               clk,
   input  logic               wen,
   input  logic [A_WIDTH-1:0] waddr,
   input  logic [D_WIDTH-1:0] wdata,
   input  logic [A_WIDTH-1:0] raddr,
   output logic [D_WIDTH-1:0] rdata
);

   logic [D_WIDTH-1:0] mem [0:(1 << A_WIDTH)-1];

   // Write on wen; read data appears one cycle after the address.
   always_ff @(posedge clk) begin
      if (wen) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/fifo_ctrl_16x8.sv
// First-word-fall-through FIFO controller around ram_dual_16x8.
// A 2-entry output buffer absorbs the RAM's one-cycle read latency so
// one push and one pop per cycle are sustained.
module fifo_ctrl_16x8
   import fifo_ctrl_16x8_pkg::*;
#(
   parameter int unsigned D_WIDTH = FIFO_D_WIDTH,
   parameter int unsigned A_WIDTH = FIFO_A_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [D_WIDTH-1:0] in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [D_WIDTH-1:0] out_data,
   input  logic               out_ready,
   output logic [A_WIDTH:0]   level
);

   localparam logic [A_WIDTH:0] DEPTH = {1'b1, {A_WIDTH{1'b0}}};

   logic [A_WIDTH-1:0] wptr;
   logic [A_WIDTH-1:0] rptr;
   logic [A_WIDTH:0]   ram_cnt;
   logic               pend;
   logic [1:0]         buf_cnt;
   logic               hd;
   logic [D_WIDTH-1:0] buf_mem [0:1];
   logic [D_WIDTH-1:0] rdata;
   logic               push;
   logic               pop;
   logic               fetch;

   ram_dual_16x8 #(
      .D_WIDTH (D_WIDTH),
      .A_WIDTH (A_WIDTH)
   ) u_ram (
      .clk   (clk),
      .wen   (push),
      .waddr (wptr),
      .wdata (in_data),
      .raddr (rptr),
      .rdata (rdata)
   );

   // Handshakes, fetch decision and outputs, all forced idle during reset.
   always_comb begin
      in_ready  = !rst && (ram_cnt != DEPTH);
      out_valid = !rst && (buf_cnt != 2'd0);
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
      fetch     = !rst && (ram_cnt != '0) && fetch_ok(buf_cnt, pend, pop);
      level     = rst ? '0
                      : ram_cnt + (A_WIDTH+1)'(pend) + (A_WIDTH+1)'(buf_cnt);
      out_data  = rst ? '0 : buf_mem[hd];
   end

   // Pointer, occupancy and output-buffer state.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr       <= '0;
         rptr       <= '0;
         ram_cnt    <= '0;
         pend       <= 1'b0;
         buf_cnt    <= '0;
         hd         <= 1'b0;
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (fetch) begin
            rptr <= rptr + 1'b1;
         end
         if (push && !fetch) begin
            ram_cnt <= ram_cnt + 1'b1;
         end else if (fetch && !push) begin
            ram_cnt <= ram_cnt - 1'b1;
         end
         pend <= fetch;
         // With a read in flight the buffer holds at most one word, so the
         // tail slot is the head slot offset by the current count; this
         // remains correct when that head word is popped in the same cycle.
         if (pend) begin
            buf_mem[hd ^ buf_cnt[0]] <= rdata;
         end
         if (pend && !pop) begin
            buf_cnt <= buf_cnt + 1'b1;
         end else if (pop && !pend) begin
            buf_cnt <= buf_cnt - 1'b1;
         end
         if (pop) begin
            hd <= ~hd;
         end
      end
   end

endmodule

// File: tb/tb_fifo_ctrl_16x8.sv
`timescale 1ns/1ps
module tb_fifo_ctrl_16x8;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [4:0] level;

   int checks = 0;
   int errors = 0;

   // Reference model: the words accepted and not yet delivered, in order.
   logic [7:0] exp_q [$];

   fifo_ctrl_16x8 #(.D_WIDTH(8), .A_WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .level     (level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   // Monitor: level equals words held, pops match the queue, head stable when stalled.
   logic       stall;
   logic [7:0] stall_data;
   initial begin
      stall = 1'b0;
      stall_data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            stall = 1'b0;
         end else begin
            chk("level", 32'(level), 32'(exp_q.size()));
            if (stall) begin
               chk("stall_valid", 32'(out_valid), 32'd1);
               chk("stall_data", 32'(out_data), 32'(stall_data));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
               end else begin
                  chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
               end
            end
            if (in_valid && in_ready) begin
               exp_q.push_back(in_data);
            end
            stall      = out_valid && !out_ready;
            stall_data = out_data;
         end
      end
   end

   task automatic drain(input int limit);
      int n;
      for (n = 0; n < limit; n++) begin
         cyc();
         in_valid  = 1'b0;
         out_ready = 1'b1;
         mid();
         if (exp_q.size() == 0 && !out_valid) break;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      cyc();
      out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int p;
      int pops;
      int first;
      int last;
      int seen;

      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;

      // Reset state
      cyc();
      cyc();
      mid();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      cyc();
      rst = 1'b0;
      mid();
      chk("post_rst_ready", 32'(in_ready), 32'd1);
      chk("post_rst_valid", 32'(out_valid), 32'd0);

      // Single word fall-through latency
      cyc(); in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0; mid();
      chk("lat_lvl0", 32'(level), 32'd0);
      chk("lat_ov0", 32'(out_valid), 32'd0);
      cyc(); in_valid = 1'b0; mid();
      chk("lat_lvl1", 32'(level), 32'd1);
      chk("lat_ov1", 32'(out_valid), 32'd0);
      cyc(); mid();
      chk("lat_lvl2", 32'(level), 32'd1);
      chk("lat_ov2", 32'(out_valid), 32'd0);
      cyc(); out_ready = 1'b1; mid();
      chk("lat_lvl3", 32'(level), 32'd1);
      chk("lat_ov3", 32'(out_valid), 32'd1);
      chk("lat_data", 32'(out_data), 32'hA5);
      cyc(); out_ready = 1'b0; mid();
      chk("lat_lvl4", 32'(level), 32'd0);
      chk("lat_ov4", 32'(out_valid), 32'd0);

      // Fill to capacity with the consumer stalled
      for (int i = 0; i < 18; i++) begin
         cyc(); in_valid = 1'b1; in_data = 8'(i); mid();
         chk("fill_ready", 32'(in_ready), 32'd1);
      end
      cyc(); in_valid = 1'b0; mid();
      chk("full_ready", 32'(in_ready), 32'd0);
      chk("full_level", 32'(level), 32'd18);
      // Full RAM: pop while a push is offered; no push that cycle
      cyc(); in_valid = 1'b1; in_data = 8'h12; out_ready = 1'b1; mid();
      chk("full_pop_ready", 32'(in_ready), 32'd0);
      cyc(); mid();
      chk("ready_back", 32'(in_ready), 32'd1);
      drain(60);

      // Streaming: 64 words, one per cycle after the fill latency
      p = 0; pops = 0; first = -1; last = -1;
      for (int c = 0; c < 200; c++) begin
         cyc();
         in_valid  = (p < 64);
         in_data   = 8'(p);
         out_ready = 1'b1;
         mid();
         if (in_valid) begin
            chk("stream_ready", 32'(in_ready), 32'd1);
            p++;
         end
         if (out_valid) begin
            if (first < 0) first = c;
            last = c;
            pops++;
         end
         if (pops == 64) break;
      end
      chk("stream_pops", 32'(pops), 32'd64);
      chk("stream_first", 32'(first), 32'd3);
      chk("stream_span", 32'(last - first + 1), 32'd64);
      drain(20);

      // Reset while words are queued and a fetch is in flight
      for (int i = 0; i < 10; i++) begin
         cyc(); in_valid = 1'b1; in_data = 8'(8'h50 + i); out_ready = 1'b0; mid();
      end
      cyc(); in_valid = 1'b0; mid();
      cyc(); out_ready = 1'b1; mid();
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      cyc(); out_ready = 1'b0; rst = 1'b1; mid();
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_level", 32'(level), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'd0);
      cyc(); rst = 1'b0; mid();
      chk("after_rst_valid", 32'(out_valid), 32'd0);
      chk("after_rst_level", 32'(level), 32'd0);
      chk("after_rst_ready", 32'(in_ready), 32'd1);
      cyc(); in_valid = 1'b1; in_data = 8'h3C; mid();
      cyc(); in_valid = 1'b0; out_ready = 1'b1;
      seen = 0;
      for (int n = 0; n < 10; n++) begin
         mid();
         if (out_valid) begin
            seen = 1;
            chk("first_after_rst", 32'(out_data), 32'h3C);
            break;
         end
         cyc();
      end
      chk("first_after_rst_seen", 32'(seen), 32'd1);
      drain(20);

      // Random traffic, 50% valid / 50% ready
      p = 0;
      for (int c = 0; c < 20000; c++) begin
         cyc();
         in_valid  = (p < 1000) && ($urandom_range(1, 0) == 1);
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(1, 0) == 1);
         mid();
         if (in_valid && in_ready) p++;
         if (p == 1000) break;
      end
      chk("random_pushes", 32'(p), 32'd1000);
      drain(100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
